mic_sample_meter: RTL
=====================

// Module: mic_sample_meter
// PURPOSE
//  Downstream consumer of the SPI microphone receiver; paces its conversions and turns samples into levels.
//  Paces conversions by pulsing the receiver's START at a fixed sample rate and captures DATA when DONE rises.
//  Converts the 12-bit offset-binary sample to signed and streams it out.
//  Computes mean-absolute level and peak magnitude over a 2^LOG2_WIN-sample window for display/PWM stages.
// PARAMETERS
//  SAMPLE_DIV  2500  CLK cycles between conversion requests (100 MHz -> 40 kHz); must be >= 512
//  LOG2_WIN    8     log2 of samples per level window (1..12)
//  TIMEOUT     4096  CLK cycles allowed for DONE to fall or rise before a transaction is abandoned
// PORTS
//  CLK           in   1   system clock; same clock as the receiver
//  RST           in   1   asynchronous, active-high reset
//  ENABLE        in   1   run sampling; low = stop after the current transaction
//  SPI_DATA      in   16  receiver DATA; bits [11:0] hold the sample
//  SPI_DONE      in   1   receiver DONE (high = idle/complete)
//  SPI_START     out  1   receiver START request
//  SAMPLE        out  12  signed sample (two's complement)
//  SAMPLE_VALID  out  1   1-cycle strobe, SAMPLE updated
//  LEVEL         out  12  mean |sample| of the last complete window
//  PEAK          out  12  max |sample| of the last complete window
//  LEVEL_VALID   out  1   1-cycle strobe, LEVEL/PEAK updated
//  OVERRUN       out  1   sticky: tick arrived while a transaction was in flight
//  TIMEOUT_ERR   out  1   sticky: a transaction was abandoned
// BEHAVIOUR
//  Reset: every output is 0, the FSM is IDLE, the accumulator, peak, sample counter and tick divider are 0.
//  RST mid-transaction drops START immediately; no capture is made.
//  SPI_DONE passes through a 2-flop synchroniser (done_s); all decisions use done_s.
//  Tick: the divider counts 0..SAMPLE_DIV-1 while ENABLE=1 and wraps, giving a 1-cycle tick at wrap.
//   While ENABLE=0 the divider is held at 0.
//  FSM:
//   IDLE: on tick and done_s=1 -> REQ.
//   REQ: START=1 until done_s=0 -> BUSY. If TIMEOUT expires first -> IDLE, set TIMEOUT_ERR.
//   BUSY: START=0. When done_s=1 -> CAPT. If TIMEOUT expires first -> IDLE, set TIMEOUT_ERR.
//   CAPT: latch SPI_DATA[11:0] (stable >= 2 CLK by then), SAMPLE_VALID=1 -> ACC.
//   ACC: update the window, -> IDLE.
//  START must be low in every state except REQ.
//   The receiver loops without reporting DONE while START is held, so START must drop in BUSY.
//  A tick in any non-IDLE state is dropped and sets OVERRUN. Sticky flags clear only on RST.
//  Conversion: SAMPLE = {~d[11], d[10:0]} (d - 2048). SPI_DATA[15:12] are ignored.
//   |SAMPLE| is a 12-bit unsigned value in 0..2048; -2048 gives 2048.
//  Window: the accumulator is (12+LOG2_WIN) bits and cannot overflow; peak is the running max of |SAMPLE|.
//   On the 2^LOG2_WIN-th sample (count wraps to 0) the following happen in the same cycle:
//    LEVEL = (acc + mag) >> LOG2_WIN, truncated; LEVEL = 2048 only for an all-(-2048) window.
//    PEAK = max(peak, mag).
//    LEVEL_VALID strobes 1 cycle, one cycle after that sample's SAMPLE_VALID.
//    acc and peak restart at 0.
//  Latency: capture is 1 CLK after done_s rises; LEVEL_VALID follows 1 CLK after SAMPLE_VALID.
//  ENABLE falling: the in-flight transaction completes and its sample is output.
//   The partial window (acc, peak, count) is cleared when the FSM returns to IDLE with ENABLE=0.
//   LEVEL and PEAK keep their last values.
// STRUCTURE
//  Package mic_pkg: MIC_BITS=12, MIC_OFFSET=12'd2048, FSM state encoding (IDLE, REQ, BUSY, CAPT, ACC).
//  Sub-module: sample_tick_gen (SAMPLE_DIV divider with enable, 1-cycle tick).
//  The FSM, synchroniser and window datapath stay in this module.
// TESTING
//  Drive a behavioural receiver model (DONE drops 3 CLK after START, rises 200 CLK later).
//  1 SPI_DATA=0x0800 -> SAMPLE=0x000; SPI_DATA=0x0FFF -> SAMPLE=0x7FF; SPI_DATA=0xF000 -> SAMPLE=0x800.
//    Each gives exactly one SAMPLE_VALID.
//  2 LOG2_WIN=2, samples d = 0x800, 0xA00, 0x600, 0x000 (mags 0, 512, 512, 2048):
//    -> LEVEL=768, PEAK=2048, one LEVEL_VALID one cycle after the 4th SAMPLE_VALID.
//  3 Hold DONE=1 after START (model never responds):
//    -> START drops after TIMEOUT cycles, TIMEOUT_ERR=1, the FSM recovers on the next tick.
//  4 SAMPLE_DIV=512 with a 700-CLK receiver -> OVERRUN=1. Every other tick is served and no sample is corrupted.
//  5 Assert RST during BUSY -> START=0 and all outputs 0 asynchronously.
//    After release the first capture occurs only after a full new REQ/BUSY cycle.
//  6 Drop ENABLE mid-window -> the in-flight sample is still output, no LEVEL_VALID is produced.
//    The next window after re-enable averages only new samples.

Source files
------------

// File: rtl/mic_pkg.sv
// Shared constants, FSM encoding and sample conversion helpers for the microphone meter.
package mic_pkg;

  localparam int unsigned MIC_BITS = 12;
  localparam logic [MIC_BITS-1:0] MIC_OFFSET = 12'd2048;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_BUSY,
    ST_CAPT,
    ST_ACC
  } mic_state_e;

  // Offset-binary to two's complement: subtracting 2048 only flips the MSB.
  function automatic logic [MIC_BITS-1:0] to_signed(input logic [MIC_BITS-1:0] d);
    return {~d[MIC_BITS-1], d[MIC_BITS-2:0]};
  endfunction

  // Magnitude straight from offset binary, so -2048 yields 2048 without a 13th bit.
  function automatic logic [MIC_BITS-1:0] mag_of(input logic [MIC_BITS-1:0] d);
    return d[MIC_BITS-1] ? (d - MIC_OFFSET) : (MIC_OFFSET - d);
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running conversion pacer: one-cycle tick every SAMPLE_DIV clocks while enabled.
module sample_tick_gen #(
  parameter int unsigned SAMPLE_DIV = 2500
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_DIV);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!enable) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CNT_W'(SAMPLE_DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CNT_W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/mic_sample_meter.sv
// Paces the SPI microphone receiver, converts samples to signed and
// reports mean-absolute level and peak over a 2^LOG2_WIN-sample window.
module mic_sample_meter
  import mic_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 2500,
  parameter int unsigned LOG2_WIN   = 8,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [15:0]         spi_data,
  input  logic                spi_done,
  output logic                spi_start,
  output logic [MIC_BITS-1:0] sample,
  output logic                sample_valid,
  output logic [MIC_BITS-1:0] level,
  output logic [MIC_BITS-1:0] peak,
  output logic                level_valid,
  output logic                overrun,
  output logic                timeout_err
);

  localparam int unsigned ACC_W = MIC_BITS + LOG2_WIN;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  logic                tick;
  logic                done_m;
  logic                done_s;
  mic_state_e          state;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [MIC_BITS-1:0] mag;
  logic [ACC_W-1:0]    acc;
  logic [MIC_BITS-1:0] win_peak;
  logic [LOG2_WIN-1:0] win_cnt;
  logic [ACC_W-1:0]    acc_sum_c;
  logic [MIC_BITS-1:0] peak_next_c;
  logic                tmo_hit_c;
  logic                unused_data_hi;

  assign unused_data_hi = ^spi_data[15:MIC_BITS];

  sample_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (tick)
  );

  // DONE crosses in from the receiver's SPI timing domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_m <= 1'b0;
      done_s <= 1'b0;
    end else begin
      done_m <= spi_done;
      done_s <= done_m;
    end
  end

  always_comb begin
    acc_sum_c   = acc + ACC_W'(mag);
    peak_next_c = (mag > win_peak) ? mag : win_peak;
    tmo_hit_c   = (tmo_cnt == TMO_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      spi_start    <= 1'b0;
      tmo_cnt      <= '0;
      mag          <= '0;
      acc          <= '0;
      win_peak     <= '0;
      win_cnt      <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      level        <= '0;
      peak         <= '0;
      level_valid  <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      level_valid  <= 1'b0;
      if (tick && state != ST_IDLE) overrun <= 1'b1;

      case (state)
        ST_IDLE: begin
          // A stopped meter discards its partial window.
          if (!enable) begin
            acc      <= '0;
            win_peak <= '0;
            win_cnt  <= '0;
          end
          if (tick && done_s) begin
            state     <= ST_REQ;
            spi_start <= 1'b1;
            tmo_cnt   <= '0;
          end
        end
        ST_REQ: begin
          if (!done_s) begin
            state     <= ST_BUSY;
            spi_start <= 1'b0;
            tmo_cnt   <= '0;
          end else if (tmo_hit_c) begin
            state       <= ST_IDLE;
            spi_start   <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        ST_BUSY: begin
          if (done_s) begin
            state <= ST_CAPT;
          end else if (tmo_hit_c) begin
            state       <= ST_IDLE;
            timeout_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        ST_CAPT: begin
          sample       <= to_signed(spi_data[MIC_BITS-1:0]);
          mag          <= mag_of(spi_data[MIC_BITS-1:0]);
          sample_valid <= 1'b1;
          state        <= ST_ACC;
        end
        ST_ACC: begin
          if (&win_cnt) begin
            level       <= acc_sum_c[ACC_W-1:LOG2_WIN];
            peak        <= peak_next_c;
            level_valid <= 1'b1;
            acc         <= '0;
            win_peak    <= '0;
          end else begin
            acc      <= acc_sum_c;
            win_peak <= peak_next_c;
          end
          win_cnt <= win_cnt + LOG2_WIN'(1);
          state   <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          spi_start <= 1'b0;
        end
      endcase
    end
  end

endmodule
